// File: rtl/lca_multicycle_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared SLICE-bit lookahead-carry slice per clock,
// least-significant slice first, with a valid/ready handshake on each side.
module lca_multicycle_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry_r, cout_r, ovf_r;
  logic [IDXW-1:0]  idx;
  logic [SLICE-1:0] sa, sb, p, g, s;
  logic [SLICE:0]   c;
  logic             acc, term;
  logic             accept, last;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  always_comb begin
    sa = '0;
    sb = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDXW'(k)) begin
        sa = a_r[k*SLICE +: SLICE];
        sb = b_r[k*SLICE +: SLICE];
      end
    end
  end

  assign p = sa ^ sb;
  assign g = sa & sb;

  // Each carry is a flat sum-of-products over g, p and carry_r rather than a ripple chain.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    for (int i = 0; i <= SLICE; i++) begin
      term = carry_r;
      for (int m = 0; m < i; m++) term = term & p[m];
      acc = term;
      for (int k = 0; k < i; k++) begin
        term = g[k];
        for (int m = k + 1; m < i; m++) term = term & p[m];
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

  assign s = p ^ c[SLICE-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      sum_r   <= '0;
      carry_r <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < N; k++) begin
        if (idx == IDXW'(k)) sum_r[k*SLICE +: SLICE] <= s;
      end
      carry_r <= c[SLICE];
      // idx parks at the last slice so it never wraps inside an operation.
      if (last) begin
        cout_r <= c[SLICE];
        ovf_r  <= c[SLICE-1] ^ c[SLICE];
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule
